// File: rtl/player_anim_pkg.sv
// Shared pose encoding, per-pose frame counts and controller direction codes.
// Imported by the decoder, the sequencer and the bench.
package player_anim_pkg;

    typedef enum logic [2:0] {
        POSE_STAND   = 3'd0,
        POSE_RUN     = 3'd1,
        POSE_AIM_UP  = 3'd2,
        POSE_PRONE   = 3'd3,
        POSE_DIAG_DN = 3'd4,
        POSE_DIAG_UP = 3'd5,
        POSE_AIR     = 3'd6
    } pose_t;

    // Entry 7 has no pose; it holds 1 so a stray index still wraps safely.
    localparam logic [2:0] POSE_FRAMES [8] = '{3'd1, 3'd6, 3'd1, 3'd1, 3'd3, 3'd3, 3'd4, 3'd1};

    localparam logic [3:0] DIR_NONE  = 4'd0;
    localparam logic [3:0] DIR_DOWN  = 4'd1;
    localparam logic [3:0] DIR_RIGHT = 4'd2;
    localparam logic [3:0] DIR_UP    = 4'd3;
    localparam logic [3:0] DIR_LEFT  = 4'd4;
    localparam logic [3:0] DIR_UR    = 4'd5;
    localparam logic [3:0] DIR_UL    = 4'd6;
    localparam logic [3:0] DIR_DR    = 4'd7;
    localparam logic [3:0] DIR_DL    = 4'd8;

endpackage

// File: rtl/player_anim_sequencer_if.sv
// Controller/physics inputs and sprite-mux outputs of the animation sequencer.
// facing_left exists only when PLAYER_FACING_EN is defined.
interface player_anim_sequencer_if;
    logic       frame_tick;
    logic [4:0] keycode;
    logic       onPlatform;
    logic [2:0] pose_sel;
    logic [2:0] frame_idx;
    logic       anim_wrap;
    logic       pose_changed;
`ifdef PLAYER_FACING_EN
    logic       facing_left;
`endif

    modport master (
        output frame_tick, keycode, onPlatform,
`ifdef PLAYER_FACING_EN
        input  facing_left,
`endif
        input  pose_sel, frame_idx, anim_wrap, pose_changed
    );

    modport slave (
        input  frame_tick, keycode, onPlatform,
`ifdef PLAYER_FACING_EN
        output facing_left,
`endif
        output pose_sel, frame_idx, anim_wrap, pose_changed
    );
endinterface

// File: rtl/player_anim_sequencer_pose_decode.sv
// Combinational keycode/platform-contact to target pose; airborne or jumping wins.
// Invalid direction codes fall back to STAND.
module pose_decode
    import player_anim_pkg::*;
(
    input  logic [4:0] keycode_i,
    input  logic       onPlatform_i,
    output pose_t      target_o
);
    always_comb begin
        target_o = POSE_STAND;
        if (!onPlatform_i || keycode_i[4]) begin
            target_o = POSE_AIR;
        end else begin
            unique case (keycode_i[3:0])
                DIR_DOWN:         target_o = POSE_PRONE;
                DIR_RIGHT:        target_o = POSE_RUN;
                DIR_UP:           target_o = POSE_AIM_UP;
                DIR_LEFT:         target_o = POSE_RUN;
                DIR_UR, DIR_UL:   target_o = POSE_DIAG_UP;
                DIR_DR, DIR_DL:   target_o = POSE_DIAG_DN;
                default:          target_o = POSE_STAND;
            endcase
        end
    end
endmodule

// File: rtl/player_anim_sequencer.sv
// Per-video-frame pose FSM plus frame-index stepper; all outputs registered, 1 cycle after frame_tick.
// Optional facing_left register under PLAYER_FACING_EN.
module player_anim_sequencer
    import player_anim_pkg::*;
#(
    parameter int unsigned TICKS_PER_FRAME = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    player_anim_sequencer_if.slave  bus
);
    localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_FRAME - 1);

    pose_t      target;
    pose_t      pose_q;
    logic [2:0] frame_q, frame_d;
    logic [3:0] tick_q;
    logic       wrap_q, chg_q;
    logic       last_frame;

    pose_decode u_pose_decode (
        .keycode_i    (bus.keycode),
        .onPlatform_i (bus.onPlatform),
        .target_o     (target)
    );

    assign last_frame = (frame_q == POSE_FRAMES[pose_q] - 3'd1);
    assign frame_d    = last_frame ? 3'd0 : frame_q + 3'd1;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pose_q  <= POSE_STAND;
            frame_q <= 3'd0;
            tick_q  <= 4'd0;
            wrap_q  <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            chg_q  <= 1'b0;
            if (bus.frame_tick) begin
                // A pose change pre-empts any frame step due on the same tick.
                if (target != pose_q) begin
                    pose_q  <= target;
                    frame_q <= 3'd0;
                    tick_q  <= 4'd0;
                    chg_q   <= 1'b1;
                end else if (tick_q == TICK_LAST) begin
                    tick_q  <= 4'd0;
                    frame_q <= frame_d;
                    wrap_q  <= last_frame;
                end else begin
                    tick_q  <= tick_q + 4'd1;
                end
            end
        end
    end

`ifdef PLAYER_FACING_EN
    logic facing_q;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            facing_q <= 1'b0;
        end else if (bus.frame_tick && target != POSE_AIR) begin
            unique case (bus.keycode[3:0])
                DIR_LEFT, DIR_UL, DIR_DL:  facing_q <= 1'b1;
                DIR_RIGHT, DIR_UR, DIR_DR: facing_q <= 1'b0;
                default:                   facing_q <= facing_q;
            endcase
        end
    end

    assign bus.facing_left = facing_q;
`endif

    assign bus.pose_sel     = pose_q;
    assign bus.frame_idx    = frame_q;
    assign bus.anim_wrap    = wrap_q;
    assign bus.pose_changed = chg_q;
endmodule

// File: tb/tb_player_anim_sequencer.sv
// Directed vector table plus hand sequences for reset, tick-gating and facing.
module tb_player_anim_sequencer;
    import player_anim_pkg::*;

    typedef struct {
        logic [4:0] k;
        logic       p;
        logic [2:0] pose;
        logic [2:0] fr;
        logic       w;
        logic       c;
    } vec_t;

    logic Clk = 1'b0;
    logic Reset;
    int   n_cmp  = 0;
    int   n_miss = 0;
    vec_t vt[$];

    player_anim_sequencer_if bus();

    player_anim_sequencer #(.TICKS_PER_FRAME(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s[%0d] got {pose,frame,wrap,chg}=%b_%b_%b_%b want %b_%b_%b_%b",
                     nm, idx, act[7:5], act[4:2], act[1], act[0], exp[7:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [7:0] outs();
        return {bus.pose_sel, bus.frame_idx, bus.anim_wrap, bus.pose_changed};
    endfunction

    // One frame_tick cycle; outputs are sampled on the following negedge.
    task automatic tick(input logic [4:0] k, input logic p);
        @(negedge Clk);
        bus.keycode    = k;
        bus.onPlatform = p;
        bus.frame_tick = 1'b1;
        @(negedge Clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic add(input logic [4:0] k, input logic p, input logic [2:0] pose,
                       input logic [2:0] fr, input logic w, input logic c);
        vec_t v;
        v.k = k; v.p = p; v.pose = pose; v.fr = fr; v.w = w; v.c = c;
        vt.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] snap;
        Reset = 1'b0;
        bus.frame_tick = 1'b0;
        bus.keycode    = 5'd2;
        bus.onPlatform = 1'b1;

        // Reset beats coincident ticks with a RUN-inducing keycode held.
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            bus.frame_tick = 1'b1;
            @(negedge Clk);
            chk("reset_hold", i, outs(), {3'd0, 3'd0, 1'b0, 1'b0});
        end
        bus.frame_tick = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;

        // Entry to RUN, then 24 ticks: a step every 4, wrap only on the 24th.
        add(5'd2, 1'b1, 3'd1, 3'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 24; i++)
            add(5'd2, 1'b1, 3'd1, 3'((i / 4) % 6), 1'b0 + (i == 24), 1'b0);
        // Advance to frame 2 with tick_cnt at 3, then lose the platform as the step falls due.
        for (int i = 25; i <= 35; i++)
            add(5'd2, 1'b1, 3'd1, (i >= 32) ? 3'd2 : (i >= 28 ? 3'd1 : 3'd0), 1'b0, 1'b0);
        add(5'd2, 1'b0, 3'd6, 3'd0, 1'b0, 1'b1);
        // Decode coverage: invalid code, jump+up, every direction class, same-pose aliases.
        add(5'h0B, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1);
        add(5'h13, 1'b1, 3'd6, 3'd0, 1'b0, 1'b1);
        add(5'd3,  1'b1, 3'd2, 3'd0, 1'b0, 1'b1);
        add(5'd1,  1'b1, 3'd3, 3'd0, 1'b0, 1'b1);
        add(5'd7,  1'b1, 3'd4, 3'd0, 1'b0, 1'b1);
        add(5'd8,  1'b1, 3'd4, 3'd0, 1'b0, 1'b0);
        add(5'd5,  1'b1, 3'd5, 3'd0, 1'b0, 1'b1);
        add(5'd6,  1'b1, 3'd5, 3'd0, 1'b0, 1'b0);
        add(5'd4,  1'b1, 3'd1, 3'd0, 1'b0, 1'b1);
        add(5'd0,  1'b1, 3'd0, 3'd0, 1'b0, 1'b1);
        // STAND is single-frame: index stays 0 but wrap still fires on the 4th tick.
        add(5'd9,  1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
        add(5'd0,  1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
        add(5'd0,  1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
        add(5'd0,  1'b1, 3'd0, 3'd0, 1'b1, 1'b0);

        foreach (vt[i]) begin
            tick(vt[i].k, vt[i].p);
            chk("vec", i, outs(), {vt[i].pose, vt[i].fr, vt[i].w, vt[i].c});
            @(negedge Clk);
            chk("vec_idle", i, outs(), {vt[i].pose, vt[i].fr, 1'b0, 1'b0});
        end

        // Keycode toggles without a tick must not move anything.
        snap = {3'd0, 3'd0, 1'b0, 1'b0};
        bus.keycode = 5'd2; @(negedge Clk); chk("notick", 0, outs(), snap);
        bus.keycode = 5'd3; @(negedge Clk); chk("notick", 1, outs(), snap);
        bus.keycode = 5'd2; @(negedge Clk); chk("notick", 2, outs(), snap);

        // Reset mid-animation discards progress; first tick after release re-enters RUN.
        tick(5'd2, 1'b1);
        for (int i = 0; i < 4; i++) tick(5'd2, 1'b1);
        chk("mid_pre", 0, outs(), {3'd1, 3'd1, 1'b0, 1'b0});
        @(negedge Clk);
        Reset = 1'b0;
        bus.frame_tick = 1'b1;
        @(negedge Clk);
        bus.frame_tick = 1'b0;
        Reset = 1'b1;
        chk("mid_rst", 0, outs(), {3'd0, 3'd0, 1'b0, 1'b0});
        tick(5'd2, 1'b1);
        chk("mid_post", 0, outs(), {3'd1, 3'd0, 1'b0, 1'b1});

`ifdef PLAYER_FACING_EN
        tick(5'd4, 1'b1);
        chk("face_l", 0, {7'd0, bus.facing_left}, 8'd1);
        tick(5'd0, 1'b1);
        chk("face_hold", 0, {7'd0, bus.facing_left}, 8'd1);
        chk("face_hold_pose", 0, outs(), {3'd0, 3'd0, 1'b0, 1'b1});
        tick(5'd7, 1'b1);
        chk("face_r", 0, {7'd0, bus.facing_left}, 8'd0);
        chk("face_r_pose", 0, outs(), {3'd4, 3'd0, 1'b0, 1'b1});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end
endmodule

// File: doc/player_anim_sequencer.md
# player_anim_sequencer

Sequences the player sprite animation for the Contra render path. Samples the decoded controller keycode and the platform-contact flag once per video frame. Selects one of seven player poses, then steps a frame index within that pose at a programmable rate. Sits between the keycode/physics logic and the sprite-address mux; `pose_sel` drives the mux select and `frame_idx` drives the per-pose sprite ROM offset.

## Interface
- `TICKS_PER_FRAME`, default 4: number of `frame_tick` pulses per animation-frame step; legal range 1–15.
- `Clk` input 1: system clock.
- `Reset` input 1: synchronous, active-low reset.
- `frame_tick` input 1: one-cycle pulse per video frame (vsync-derived).
- `keycode` input 5: bit 4 is jump; bits 3:0 are the direction code (0 none, 1 down, 2 right, 3 up, 4 left, 5 up-right, 6 up-left, 7 down-right, 8 down-left, 9–15 invalid).
- `onPlatform` input 1: player feet on a platform.
- `pose_sel` output 3: current pose, 0–6.
- `frame_idx` output 3: frame within the current pose.
- `anim_wrap` output 1: one-cycle pulse when `frame_idx` wraps to 0.
- `pose_changed` output 1: one-cycle pulse on the cycle `pose_sel` takes a new value.
- `facing_left` output 1: present only with `PLAYER_FACING_EN`.

## Operation
- Poses: STAND=0, RUN=1, AIM_UP=2, PRONE=3, DIAG_DN=4, DIAG_UP=5, AIR=6. This encoding is the pose FSM state.
- Target pose, combinational from inputs:
  - `!onPlatform || keycode[4]` → AIR.
  - Otherwise by direction code: 0→STAND, 1→PRONE, 2→RUN, 3→AIM_UP, 4→RUN, 5/6→DIAG_UP, 7/8→DIAG_DN, 9–15→STAND.
- Frame counts per pose: STAND 1, RUN 6, AIM_UP 1, PRONE 1, DIAG_DN 3, DIAG_UP 3, AIR 4.
- Internal `tick_cnt`: 4 bits, counts `frame_tick` pulses 0..`TICKS_PER_FRAME`-1.
- On a `frame_tick` cycle:
  - If target ≠ `pose_sel`:
    - load the target into `pose_sel`;
    - set `frame_idx`=0 and `tick_cnt`=0;
    - pulse `pose_changed`;
    - do not pulse `anim_wrap`.
  - Else if `tick_cnt`==`TICKS_PER_FRAME`-1:
    - set `tick_cnt`=0;
    - advance `frame_idx`; if it was count-1 it becomes 0 and `anim_wrap` pulses.
  - Else increment `tick_cnt`.
- Single-frame poses (count 1): `frame_idx` stays 0 but `anim_wrap` still pulses every `TICKS_PER_FRAME` ticks.
- Cycles without `frame_tick`: all state holds; `anim_wrap` and `pose_changed` are 0.

## Timing
- All outputs are registered and update on the `Clk` edge ending the `frame_tick` cycle, giving 1-cycle latency from that tick.
- Inputs are sampled only in `frame_tick` cycles; input changes between ticks are ignored.
- Reset (`Reset`=0 at the edge) forces: `pose_sel`=STAND, `frame_idx`=0, `tick_cnt`=0, `anim_wrap`=0, `pose_changed`=0, `facing_left`=0.
- Reset takes priority over a coincident `frame_tick`.
- Reset mid-animation discards all progress; the first tick after release evaluates the target normally.
- Pose change and frame step in the same tick: the pose change wins; `frame_idx`=0 and no wrap pulse.
- `frame_idx` never reaches or exceeds the current pose's frame count.

## Configuration
- `PLAYER_FACING_EN`
- Defined:
  - `facing_left` exists and updates on `frame_tick` only.
  - Set to 1 for codes 4, 6, 8; cleared to 0 for codes 2, 5, 7.
  - Holds for all other codes and for AIR.
  - Changing facing alone does not change pose and does not reset `frame_idx`.
- Undefined: the port and its register are absent; all other behaviour is identical.

## Structure
- Shared package `player_anim_pkg` holds:
  - `pose_t` enum (3-bit, values above);
  - `POSE_FRAMES` constant array indexed by `pose_t`;
  - direction-code localparams.
- One sub-module, `pose_decode`: combinational keycode/`onPlatform` → target `pose_t`. The sequencer instantiates it and holds the FSM, counters and facing register.

## Test plan
- Reset with `keycode`=2 and `onPlatform`=1 held → `pose_sel`=0, `frame_idx`=0 until release. First tick after release → `pose_sel`=1, `pose_changed`=1 for exactly one cycle.
- RUN held with `TICKS_PER_FRAME`=4, 24 ticks after entry → `frame_idx` sequence 0,1,2,3,4,5,0, stepping every 4 ticks; `anim_wrap` pulses once, at tick 24.
- `frame_idx`=2 in RUN, `onPlatform` dropped on the same tick a step is due → `pose_sel`=6, `frame_idx`=0, `anim_wrap`=0.
- `keycode`=0x13 (jump+up) on platform → AIR. `keycode`=0x0B (invalid code) → STAND.
- `keycode` toggles 2→3→2 between ticks with no `frame_tick` → no output change.
- With `PLAYER_FACING_EN`: code 4 then code 0 → `facing_left`=1 and held. Then code 7 → `facing_left`=0, `pose_sel`=4.
